// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder and the immediate generator.
//   fmt_e          : instruction format selector (R/I/S/B)
//   OP_*           : base opcodes for the supported formats
//   *_LSB          : bit positions of the fixed instruction fields
//   imm_fits       : true when imm is the sign extension of imm[msb:0]
package inst_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_S = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  // Bits imm[63:msb] must all equal the sign bit of the field.
  function automatic logic imm_fits(input logic [63:0] imm, input int unsigned msb);
    logic [63:0] upper;
    upper = $unsigned($signed(imm) >>> msb);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational field packer.
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm : decoded fields
//   instruction : 32-bit encoded word (built from truncated imm bits)
//   err         : immediate out of range for the format, or misaligned (B)
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic [31:0] instruction,
  output logic        err
);

  always_comb begin
    instruction = '0;
    err         = 1'b0;
    unique case (fmt)
      FMT_R: begin
        instruction = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        instruction = {imm[11:0], rs1, funct3, rd, opcode};
        err         = !imm_fits(imm, 11);
      end
      FMT_S: begin
        instruction = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err         = !imm_fits(imm, 11);
      end
      FMT_B: begin
        instruction = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err         = !imm_fits(imm, 12) || imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded fields into RV64 instruction words, tags each
// accepted request with a sequential word address, 1-cycle latency with an
// output register plus one-entry skid buffer.
//   clock, reset (sync, active-low), io_flush (sync clear of pipe and address)
//   io_in_*  : request handshake and fields
//   io_out_* : result handshake, encoded word, address, range error
//   io_err_count : saturating count of accepted erroneous requests
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [1:0]        io_in_fmt,
  input  logic [6:0]        io_in_opcode,
  input  logic [4:0]        io_in_rd,
  input  logic [4:0]        io_in_rs1,
  input  logic [4:0]        io_in_rs2,
  input  logic [2:0]        io_in_funct3,
  input  logic [6:0]        io_in_funct7,
  input  logic [63:0]       io_in_imm,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [31:0]       io_out_instruction,
  output logic [ADDR_W-1:0] io_out_addr,
  output logic              io_out_err,
  output logic [15:0]       io_err_count
);

  logic [31:0]       pack_instr;
  logic              pack_err;

  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_err_q;

  logic              skid_valid_q;
  logic [31:0]       skid_instr_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic              skid_err_q;

  logic [ADDR_W-1:0] addr_cnt_q;
  logic [15:0]       err_cnt_q;

  logic              accept;
  logic              out_free;

  inst_pack u_pack (
    .fmt         (fmt_e'(io_in_fmt)),
    .opcode      (io_in_opcode),
    .rd          (io_in_rd),
    .rs1         (io_in_rs1),
    .rs2         (io_in_rs2),
    .funct3      (io_in_funct3),
    .funct7      (io_in_funct7),
    .imm         (io_in_imm),
    .instruction (pack_instr),
    .err         (pack_err)
  );

  // Ready depends only on registered skid state, gated by reset/flush inputs.
  assign io_in_ready = !skid_valid_q && reset && !io_flush;
  assign accept      = io_in_valid && io_in_ready;
  assign out_free    = !out_valid_q || io_out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      skid_err_q   <= 1'b0;
      addr_cnt_q   <= ADDR_W'(BASE_ADDR);
      err_cnt_q    <= '0;
    end else if (io_flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      addr_cnt_q   <= ADDR_W'(BASE_ADDR);
    end else begin
      if (accept) begin
        addr_cnt_q <= addr_cnt_q + 1'b1;
        if (pack_err && (err_cnt_q != 16'hFFFF)) begin
          err_cnt_q <= err_cnt_q + 16'd1;
        end
      end

      // A full skid blocks acceptance, so skid promotion and a new request
      // never compete for the output register.
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_instr_q  <= skid_instr_q;
          out_addr_q   <= skid_addr_q;
          out_err_q    <= skid_err_q;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          out_valid_q <= 1'b1;
          out_instr_q <= pack_instr;
          out_addr_q  <= addr_cnt_q;
          out_err_q   <= pack_err;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= pack_instr;
        skid_addr_q  <= addr_cnt_q;
        skid_err_q   <= pack_err;
      end
    end
  end

  assign io_out_valid       = out_valid_q;
  assign io_out_instruction = out_instr_q;
  assign io_out_addr        = out_addr_q;
  assign io_out_err         = out_err_q;
  assign io_err_count       = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_flush;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [1:0]  io_in_fmt;
  logic [6:0]  io_in_opcode;
  logic [4:0]  io_in_rd, io_in_rs1, io_in_rs2;
  logic [2:0]  io_in_funct3;
  logic [6:0]  io_in_funct7;
  logic [63:0] io_in_imm;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_instruction;
  logic [9:0]  io_out_addr;
  logic        io_out_err;
  logic [15:0] io_err_count;

  logic        n_in_ready, n_out_valid, n_out_err;
  logic [31:0] n_out_instruction;
  logic [1:0]  n_out_addr;
  logic [15:0] n_err_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_fmt(io_in_fmt), .io_in_opcode(io_in_opcode),
    .io_in_rd(io_in_rd), .io_in_rs1(io_in_rs1), .io_in_rs2(io_in_rs2),
    .io_in_funct3(io_in_funct3), .io_in_funct7(io_in_funct7), .io_in_imm(io_in_imm),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_instruction(io_out_instruction), .io_out_addr(io_out_addr),
    .io_out_err(io_out_err), .io_err_count(io_err_count)
  );

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_narrow (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(n_in_ready),
    .io_in_fmt(io_in_fmt), .io_in_opcode(io_in_opcode),
    .io_in_rd(io_in_rd), .io_in_rs1(io_in_rs1), .io_in_rs2(io_in_rs2),
    .io_in_funct3(io_in_funct3), .io_in_funct7(io_in_funct7), .io_in_imm(io_in_imm),
    .io_out_valid(n_out_valid), .io_out_ready(io_out_ready),
    .io_out_instruction(n_out_instruction), .io_out_addr(n_out_addr),
    .io_out_err(n_out_err), .io_err_count(n_err_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [63:0] imm);
    io_in_valid  = 1'b1;
    io_in_fmt    = fmt;
    io_in_opcode = op;
    io_in_rd     = rd;
    io_in_rs1    = rs1;
    io_in_rs2    = rs2;
    io_in_funct3 = f3;
    io_in_funct7 = f7;
    io_in_imm    = imm;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr, input logic err,
                         input logic [9:0] addr);
    chk({tag, ".valid"}, 64'(io_out_valid), 64'd1);
    chk({tag, ".instr"}, 64'(io_out_instruction), 64'(instr));
    chk({tag, ".err"},   64'(io_out_err), 64'(err));
    chk({tag, ".addr"},  64'(io_out_addr), 64'(addr));
  endtask

  initial begin
    reset = 1'b0; io_flush = 1'b0; io_out_ready = 1'b1;
    io_in_valid = 1'b0; io_in_fmt = '0; io_in_opcode = '0; io_in_rd = '0;
    io_in_rs1 = '0; io_in_rs2 = '0; io_in_funct3 = '0; io_in_funct7 = '0; io_in_imm = '0;
    step(); step();
    chk("rst.valid", 64'(io_out_valid), 64'd0);
    chk("rst.instr", 64'(io_out_instruction), 64'd0);
    chk("rst.addr", 64'(io_out_addr), 64'd0);
    chk("rst.err", 64'(io_out_err), 64'd0);
    chk("rst.errcnt", 64'(io_err_count), 64'd0);
    chk("rst.in_ready", 64'(io_in_ready), 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst.in_ready", 64'(io_in_ready), 64'd1);

    // Encoding and range checks, streaming with io_out_ready=1.
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF); step();
    chk_out("addi", 32'hFFF00093, 1'b0, 10'd0);
    drive(FMT_S, OP_STORE, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, 64'd8); step();
    chk_out("sd", 32'h0021B423, 1'b0, 10'd1);
    drive(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC); step();
    chk_out("beq", 32'hFE208EE3, 1'b0, 10'd2);
    drive(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048); step();
    chk_out("i_2048", 32'h80000013, 1'b1, 10'd3);
    chk("i_2048.errcnt", 64'(io_err_count), 64'd1);
    drive(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3); step();
    chk_out("b_3", 32'h00000163, 1'b1, 10'd4);
    chk("b_3.errcnt", 64'(io_err_count), 64'd2);
    drive(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_F800); step();
    chk_out("i_m2048", 32'h80000013, 1'b0, 10'd5);
    drive(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_0000_1234_5678); step();
    chk_out("add", 32'h002081B3, 1'b0, 10'd6);
    drive(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0); step();
    chk_out("sub", 32'h402081B3, 1'b0, 10'd7);
    drive(FMT_S, OP_STORE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF); step();
    chk_out("s_m1", 32'hFE000FA3, 1'b0, 10'd8);
    drive(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4096); step();
    chk_out("b_4096", 32'h80000063, 1'b1, 10'd9);
    chk("b_4096.errcnt", 64'(io_err_count), 64'd3);
    drive(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4094); step();
    chk_out("b_4094", 32'h7E000FE3, 1'b0, 10'd10);
    io_in_valid = 1'b0; step();
    chk("idle.valid", 64'(io_out_valid), 64'd0);

    // Flush clears the address counter but keeps the error count.
    io_flush = 1'b1; #1;
    chk("flush.in_ready", 64'(io_in_ready), 64'd0);
    step(); io_flush = 1'b0;
    chk("flush.errcnt", 64'(io_err_count), 64'd3);

    // Backpressure: A to output, B to skid, C blocked.
    io_out_ready = 1'b0;
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF); step();
    chk_out("bp_a", 32'hFFF00093, 1'b0, 10'd0);
    chk("bp_a.in_ready", 64'(io_in_ready), 64'd1);
    drive(FMT_S, OP_STORE, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, 64'd8); step();
    chk_out("bp_hold1", 32'hFFF00093, 1'b0, 10'd0);
    chk("bp_b.in_ready", 64'(io_in_ready), 64'd0);
    drive(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC); step();
    chk_out("bp_hold2", 32'hFFF00093, 1'b0, 10'd0);
    chk("bp_c.in_ready", 64'(io_in_ready), 64'd0);
    io_out_ready = 1'b1; step();
    chk_out("bp_b", 32'h0021B423, 1'b0, 10'd1);
    chk("bp_drain.in_ready", 64'(io_in_ready), 64'd1);
    step();
    chk_out("bp_c", 32'hFE208EE3, 1'b0, 10'd2);
    io_in_valid = 1'b0; step();
    chk("bp_end.valid", 64'(io_out_valid), 64'd0);

    // Flush mid-stream.
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF); step();
    chk_out("pre_flush", 32'hFFF00093, 1'b0, 10'd3);
    drive(FMT_S, OP_STORE, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, 64'd8);
    io_flush = 1'b1; step(); io_flush = 1'b0;
    chk("mid_flush.valid", 64'(io_out_valid), 64'd0);
    step();
    chk_out("post_flush", 32'h0021B423, 1'b0, 10'd0);
    chk("post_flush.errcnt", 64'(io_err_count), 64'd3);

    // Address wrap on the narrow instance.
    io_in_valid = 1'b0; io_flush = 1'b1; step(); io_flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0); step();
      chk($sformatf("wrap%0d.addr", i), 64'(n_out_addr), 64'(i % 4));
      chk($sformatf("wide%0d.addr", i), 64'(io_out_addr), 64'(i));
    end

    // Reset mid-stream with output and skid both occupied.
    io_out_ready = 1'b0;
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1); step(); step();
    chk("pre_rst.in_ready", 64'(io_in_ready), 64'd0);
    reset = 1'b0; step();
    chk("mid_rst.valid", 64'(io_out_valid), 64'd0);
    chk("mid_rst.instr", 64'(io_out_instruction), 64'd0);
    chk("mid_rst.errcnt", 64'(io_err_count), 64'd0);
    chk("mid_rst.in_ready", 64'(io_in_ready), 64'd0);
    reset = 1'b1; io_in_valid = 1'b0; io_out_ready = 1'b1; step();
    chk("after_rst.valid", 64'(io_out_valid), 64'd0);
    chk("after_rst.in_ready", 64'(io_in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the immediate generator: packs decoded fields (opcode, registers, funct, 64-bit immediate) into a 32-bit RV64 instruction word for R/I/S/B formats.
- Feeds the instruction-memory loader and the self-check bench. Each accepted request is tagged with a sequential word address.
- Checks that the immediate fits the format, so a round trip through the immediate generator reproduces it.
- Valid/ready on both sides, 1-cycle latency, one-entry skid buffer.

Parameters:
- ADDR_W, 10, width of the word-address counter.
- BASE_ADDR, 0, address assigned after reset or flush.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- io_flush  input  1  synchronous pipeline and address clear.
- io_in_valid  input  1  request valid.
- io_in_ready  output  1  request accepted when valid && ready.
- io_in_fmt  input  2  0=R, 1=I, 2=S, 3=B.
- io_in_opcode  input  7  opcode field.
- io_in_rd  input  5  destination register.
- io_in_rs1  input  5  source register 1.
- io_in_rs2  input  5  source register 2.
- io_in_funct3  input  3  funct3 field.
- io_in_funct7  input  7  funct7 field (R only).
- io_in_imm  input  64  sign-extended immediate.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer ready.
- io_out_instruction  output  32  encoded word.
- io_out_addr  output  ADDR_W  word address of this instruction.
- io_out_err  output  1  immediate out of range or misaligned.
- io_err_count  output  16  saturating count of accepted erroneous requests.

Behaviour:
- Reset (reset==0 at a clock edge):
  - io_out_valid=0, skid empty, address counter=BASE_ADDR, io_err_count=0.
  - io_out_instruction, io_out_addr and io_out_err are 0.
  - io_in_ready=0 while reset is low.
- Encoding, bit ranges MSB first:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Fields unused by a format are ignored.
- Range check, combinational on the inputs and registered with the result:
  - I/S: err = imm[63:11] not all equal.
  - B: err = imm[63:12] not all equal, or imm[0]==1.
  - R: err=0.
  - An erroneous request is still encoded from the truncated bits, accepted and passed downstream with io_out_err=1.
- io_err_count: +1 per accepted request with err=1; holds at 0xFFFF.
- Address: the counter value is captured with the request at acceptance, then the counter increments modulo 2^ADDR_W.
- Latency and handshake:
  - A request accepted at edge N appears at the output from the cycle after N.
  - Outputs hold stable while io_out_valid && !io_out_ready.
  - Output register plus one-entry skid buffer; io_in_ready = skid empty (registered, no combinational path from io_out_ready).
  - Accept with output register empty or draining: the request goes to the output register.
  - Accept with the output register stalled: the request goes to the skid buffer.
  - When the output drains and the skid buffer is full, the skid entry moves to the output register the same edge.
  - Order is strictly FIFO.
- Flush (io_flush==1):
  - io_in_ready=0 that cycle, so no acceptance.
  - Next edge: output and skid invalidated, counter=BASE_ADDR. io_err_count is kept.
  - A simultaneous output handshake counts as completed.
- Priority: reset > flush > normal operation.

Decomposition:
- Shared package:
  - Format enum FMT_R/FMT_I/FMT_S/FMT_B (2 bits).
  - Opcode constants OP_IMM=0x13, OP_STORE=0x23, OP_BRANCH=0x63, OP_REG=0x33.
  - Field position constants, also used by the immediate generator.
- Sub-module inst_pack: purely combinational fields+imm -> {instruction, err}.
- Top level holds the skid and output registers, address counter and error counter.

Test Plan:
- addi x1,x0,-1 (fmt I, opcode 0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFFFFFFFFFF) -> next cycle io_out_instruction=0xFFF00093, err=0, addr=0.
- sd x2,8(x3) (fmt S, opcode 0x23, f3=3, rs1=3, rs2=2, imm=8) -> 0x0021B423, err=0.
- beq x1,x2,-4 (fmt B, opcode 0x63, f3=0, imm=-4) -> 0xFE208EE3; feeding it to the immediate generator gives b_imm=-4.
- Range errors:
  - I imm=2048 -> bits[31:20]=0x800, err=1, io_err_count=1.
  - B imm=3 -> err=1, io_err_count=2.
  - I imm=-2048 -> err=0.
- Backpressure: io_out_ready=0, three back-to-back requests -> first two accepted, io_in_ready=0 from the cycle after the second. Then io_out_ready=1 -> outputs in order with addr 0,1, third accepted, addr 2.
- ADDR_W=2, five requests -> addrs 0,1,2,3,0.
- io_flush asserted mid-stream -> io_out_valid=0 next cycle, next accepted request gets addr BASE_ADDR, io_err_count unchanged.
- reset low mid-stream -> all valids 0, io_err_count=0.
